// File: rtl/wll_fifo_pkg.sv
// Shared constants and types for the wll single-clock FIFO.
// Optional error flags are enabled by defining WLL_FIFO_ERR_FLAGS_EN.
package wll_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    // Occupancy counter must hold 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wll_fifo_ram.sv
// Simple dual-port register array: one write port, one registered read port.
// The read register clears on reset; the storage itself is never cleared.
module wll_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Same-address read and write in one cycle returns the old word, which is
    // what a simultaneous push+pop on a full FIFO needs.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/wll_sync_fifo.sv
// Single-clock FIFO with global enable and registered read data (1-cycle latency).
// Define WLL_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module wll_sync_fifo
    import wll_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              wr_en,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              rd_valid,
    output logic                              full,
    output logic                              empty,
    output logic [cnt_width(DEPTH)-1:0]       count
`ifdef WLL_FIFO_ERR_FLAGS_EN
    ,
    output logic                              overflow,
    output logic                              underflow
`endif
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_W      = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push_ok, pop_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A full FIFO may still accept a push when a pop frees the slot in the same cycle.
    assign pop_ok  = en & rd_en & ~empty;
    assign push_ok = en & wr_en & (~full | pop_ok);

    wll_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WLL_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (en & wr_en & full & ~rd_en)
                overflow <= 1'b1;
            if (en & rd_en & empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wll_sync_fifo.sv
// Directed bench for wll_sync_fifo: vector table plus hand-written full/wrap/enable sequences.
// Flag checks are compiled in when WLL_FIFO_ERR_FLAGS_EN is defined.
module tb_wll_sync_fifo;
    import wll_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, rd_en;
    word_t      data_in, data_out;
    logic       rd_valid, full, empty;
    logic [3:0] count;
`ifdef WLL_FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wll_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef WLL_FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    typedef struct {
        logic       r, e, w, rd;
        word_t      din;
        word_t      x_dout;
        logic       x_rv;
        logic [3:0] x_cnt;
        logic       x_empty, x_full;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic r, input logic e, input logic w, input logic rd, input word_t d);
        @(negedge clk);
        rst = r; en = e; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input word_t d, input logic rv,
                               input logic [3:0] c, input logic e, input logic f);
        check(name, {17'd0, data_out, rd_valid, count, empty, full}, {17'd0, d, rv, c, e, f});
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input word_t din,
                                input word_t d, input logic rv, input logic [3:0] c);
        vec_t v;
        v.r = r; v.e = 1'b1; v.w = w; v.rd = rd; v.din = din;
        v.x_dout = d; v.x_rv = rv; v.x_cnt = c;
        v.x_empty = (c == 4'd0); v.x_full = (c == 4'd8);
        return v;
    endfunction

    initial begin
        word_t exp_q[$];
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // reset, basic push/pop, ordering, extra pop, push+pop on empty
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'hAA, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 8'hBB, 8'h00, 0, 2));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h01, 8'hAA, 0, 2));
        vecs.push_back(mk(0, 1, 0, 8'h02, 8'hAA, 0, 3));
        vecs.push_back(mk(0, 1, 0, 8'h03, 8'hAA, 0, 4));
        vecs.push_back(mk(0, 1, 0, 8'h04, 8'hAA, 0, 5));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'hBB, 1, 4));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h01, 1, 3));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h02, 1, 2));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h03, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h04, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h55, 8'h04, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h55, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].w, vecs[i].rd, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].x_dout, vecs[i].x_rv,
                        vecs[i].x_cnt, vecs[i].x_empty, vecs[i].x_full);
        end
`ifdef WLL_FIFO_ERR_FLAGS_EN
        check("underflow_set", {31'd0, underflow}, 32'd1);
        check("overflow_clr", {31'd0, overflow}, 32'd0);
`endif

        // overfill and drain three times so both pointers wrap
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 10; i++) begin
                drive(0, 1, 1, 0, word_t'(8'h10 + i));
                check($sformatf("fill%0d_%0d", rep, i), {27'd0, count, full},
                      {27'd0, (i < 8) ? 4'(i + 1) : 4'd8, i >= 7});
            end
            for (int i = 0; i < 8; i++) begin
                drive(0, 1, 0, 1, 0);
                check_state($sformatf("drain%0d_%0d", rep, i), word_t'(8'h10 + i), 1'b1,
                            4'(7 - i), i == 7, 1'b0);
            end
        end
`ifdef WLL_FIFO_ERR_FLAGS_EN
        check("overflow_set", {31'd0, overflow}, 32'd1);
`endif

        // simultaneous push+pop while full
        for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, word_t'(8'h10 + i));
        drive(0, 1, 1, 1, 8'h20);
        check_state("full_pushpop", 8'h10, 1'b1, 4'd8, 1'b0, 1'b1);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 1, 0);
            check($sformatf("pp_drain%0d", i), {24'd0, data_out}, {24'd0, exp_q[i]});
        end

        // enable freeze
        drive(0, 1, 1, 0, 8'h30);
        drive(0, 1, 1, 0, 8'h31);
        drive(0, 1, 1, 0, 8'h32);
        drive(0, 1, 0, 1, 0);
        check_state("pre_freeze", 8'h30, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 8'hEE);
            check_state($sformatf("freeze%0d", i), 8'h30, 1'b0, 4'd2, 1'b0, 1'b0);
`ifdef WLL_FIFO_ERR_FLAGS_EN
            check($sformatf("freeze_flags%0d", i), {30'd0, overflow, underflow}, 32'd3);
`endif
        end
        drive(0, 1, 0, 1, 0);
        check_state("post_freeze", 8'h31, 1'b1, 4'd1, 1'b0, 1'b0);

        // reset mid-stream overrides a concurrent push
        drive(1, 1, 1, 0, 8'h40);
        check_state("mid_reset", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef WLL_FIFO_ERR_FLAGS_EN
        check("flags_reset", {30'd0, overflow, underflow}, 32'd0);
`endif
        drive(0, 1, 1, 0, 8'h41);
        drive(0, 1, 0, 1, 0);
        check_state("after_reset", 8'h41, 1'b1, 4'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
